// File: rtl/dsc_s2b_decoder_if.sv
// Stream-in / result-out bundle for the stochastic-to-binary decoder.
//   sn_in, sn_valid, sn_last : serial stochastic bit, qualifier, end-of-frame marker
//   sn_ready                 : decoder can take a stream bit this cycle
//   z, len, sat              : ones count, frame length, saturation of the completed frame
//   z_valid, z_ready         : result handshake
// master = stream producer / result consumer, slave = decoder.
interface dsc_s2b_decoder_if #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned LEN_W = 16
) ();

  logic             sn_in;
  logic             sn_valid;
  logic             sn_last;
  logic             sn_ready;
  logic [OUT_W-1:0] z;
  logic [LEN_W-1:0] len;
  logic             sat;
  logic             z_valid;
  logic             z_ready;

  modport master (
    output sn_in, sn_valid, sn_last, z_ready,
    input  sn_ready, z, len, sat, z_valid
  );

  modport slave (
    input  sn_in, sn_valid, sn_last, z_ready,
    output sn_ready, z, len, sat, z_valid
  );

endinterface

// File: rtl/dsc_s2b_decoder.sv
// Stochastic-to-binary decoder: accepts one serial bitstream frame under a
// valid/ready handshake, counts ones and frame length with saturation, and
// presents the result under a valid/ready output handshake.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   en    : stream acceptance enable (state held when low)
//   clr   : synchronous abort, drops frame in progress and any held result
//   busy  : frame in progress
//   s     : stream/result bundle (slave side)
module dsc_s2b_decoder #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  output logic                busy,
  dsc_s2b_decoder_if.slave    s
);

  localparam logic [OUT_W-1:0] Z_MAX = '1;
  localparam logic [LEN_W-1:0] L_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] lcnt_q, lcnt_d;
  logic             sat_f_q, sat_f_d;
  logic [OUT_W-1:0] z_q, z_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             z_valid_q, z_valid_d;
  logic             busy_q, busy_d;

  logic             sn_ready_c;
  logic             accept_c;
  logic [OUT_W-1:0] cnt_inc_c;
  logic [LEN_W-1:0] lcnt_inc_c;
  logic             sat_inc_c;

  // Ready never looks at sn_valid; rst gating keeps it low throughout reset.
  assign sn_ready_c = rst & en & (state_q != HOLD) & ~clr;
  assign accept_c   = s.sn_valid & sn_ready_c;

  // Saturating update of both counters for one accepted bit.
  always_comb begin
    cnt_inc_c  = cnt_q;
    lcnt_inc_c = lcnt_q;
    sat_inc_c  = sat_f_q;
    if (s.sn_in) begin
      if (cnt_q == Z_MAX) sat_inc_c = 1'b1;
      else                cnt_inc_c = cnt_q + OUT_W'(1);
    end
    if (lcnt_q == L_MAX) sat_inc_c  = 1'b1;
    else                 lcnt_inc_c = lcnt_q + LEN_W'(1);
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    sat_f_d = sat_f_q;
    z_d     = z_q;
    len_d   = len_q;
    sat_d   = sat_q;

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      lcnt_d  = '0;
      sat_f_d = 1'b0;
      z_d     = '0;
      len_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Frame start: counters reload from the first bit, sat flag restarts.
          if (accept_c) begin
            cnt_d   = OUT_W'(s.sn_in);
            lcnt_d  = LEN_W'(1);
            sat_f_d = 1'b0;
            if (s.sn_last) begin
              state_d = HOLD;
              z_d     = OUT_W'(s.sn_in);
              len_d   = LEN_W'(1);
              sat_d   = 1'b0;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept_c) begin
            cnt_d   = cnt_inc_c;
            lcnt_d  = lcnt_inc_c;
            sat_f_d = sat_inc_c;
            // Result captures the counts including the final bit.
            if (s.sn_last) begin
              state_d = HOLD;
              z_d     = cnt_inc_c;
              len_d   = lcnt_inc_c;
              sat_d   = sat_inc_c;
            end
          end
        end
        HOLD: begin
          if (s.z_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags follow the next state so they align with the state register.
  always_comb begin
    z_valid_d = (state_d == HOLD);
    busy_d    = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lcnt_q    <= '0;
      sat_f_q   <= 1'b0;
      z_q       <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      z_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      sat_f_q   <= sat_f_d;
      z_q       <= z_d;
      len_q     <= len_d;
      sat_q     <= sat_d;
      z_valid_q <= z_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign s.sn_ready = sn_ready_c;
  assign s.z        = z_q;
  assign s.len      = len_q;
  assign s.sat      = sat_q;
  assign s.z_valid  = z_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dsc_s2b_decoder.sv
// Bench for dsc_s2b_decoder: two instances (16/16 and 4/8 widths) share one
// stimulus stream; a frame-level model predicts ready, status and results.
module tb_dsc_s2b_decoder;

  localparam int unsigned AZ = 16;
  localparam int unsigned AL = 16;
  localparam int unsigned BZ = 4;
  localparam int unsigned BL = 8;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst, en, clr, sn_in, sn_valid, sn_last, z_ready;
  logic busy_a, busy_b;

  dsc_s2b_decoder_if #(.OUT_W(AZ), .LEN_W(AL)) ifa ();
  dsc_s2b_decoder_if #(.OUT_W(BZ), .LEN_W(BL)) ifb ();

  assign ifa.sn_in    = sn_in;
  assign ifa.sn_valid = sn_valid;
  assign ifa.sn_last  = sn_last;
  assign ifa.z_ready  = z_ready;
  assign ifb.sn_in    = sn_in;
  assign ifb.sn_valid = sn_valid;
  assign ifb.sn_last  = sn_last;
  assign ifb.z_ready  = z_ready;

  dsc_s2b_decoder #(.OUT_W(AZ), .LEN_W(AL)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .busy(busy_a), .s(ifa.slave)
  );
  dsc_s2b_decoder #(.OUT_W(BZ), .LEN_W(BL)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .busy(busy_b), .s(ifb.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model: running counts, pending result, handshake flags.
  bit          m_hold, m_busy, m_acc;
  int unsigned m_ones, m_n, r_ones, r_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clip(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] exp_sat(input int unsigned wz, input int unsigned wl);
    return ((r_ones > ((32'd1 << wz) - 1)) || (r_n > ((32'd1 << wl) - 1))) ? 1 : 0;
  endfunction

  function automatic bitq_t make_frame(input int n, input int k);
    bitq_t q;
    bit t;
    int j;
    for (int i = 0; i < n; i++) q.push_back(i < k);
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = q[i]; q[i] = q[j]; q[j] = t;
    end
    return q;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_busy = 0; m_acc = 0;
    m_ones = 0; m_n = 0; r_ones = 0; r_n = 0;
  endtask

  task automatic model_update();
    m_acc = 0;
    if (clr) begin
      model_reset();
    end else if (m_hold) begin
      if (z_ready) m_hold = 0;
    end else if (en && sn_valid) begin
      m_acc = 1;
      m_ones += sn_in;
      m_n++;
      if (sn_last) begin
        r_ones = m_ones; r_n = m_n;
        m_ones = 0; m_n = 0;
        m_hold = 1; m_busy = 0;
      end else begin
        m_busy = 1;
      end
    end
  endtask

  task automatic check_outs();
    chk("z_valid_a", ifa.z_valid, m_hold);
    chk("busy_a",    busy_a,      m_busy);
    chk("z_a",       ifa.z,       clip(r_ones, AZ));
    chk("len_a",     ifa.len,     clip(r_n, AL));
    chk("sat_a",     ifa.sat,     exp_sat(AZ, AL));
    chk("z_valid_b", ifb.z_valid, m_hold);
    chk("busy_b",    busy_b,      m_busy);
    chk("z_b",       ifb.z,       clip(r_ones, BZ));
    chk("len_b",     ifb.len,     clip(r_n, BL));
    chk("sat_b",     ifb.sat,     exp_sat(BZ, BL));
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_sn_ready_a"}, ifa.sn_ready, 0);
    chk({ph, "_z_valid_a"},  ifa.z_valid,  0);
    chk({ph, "_busy_a"},     busy_a,       0);
    chk({ph, "_z_a"},        ifa.z,        0);
    chk({ph, "_len_a"},      ifa.len,      0);
    chk({ph, "_sat_a"},      ifa.sat,      0);
    chk({ph, "_sn_ready_b"}, ifb.sn_ready, 0);
    chk({ph, "_z_b"},        ifb.z,        0);
    chk({ph, "_len_b"},      ifb.len,      0);
    chk({ph, "_sat_b"},      ifb.sat,      0);
  endtask

  // One clock: ready checked mid-cycle, model and outputs after the edge.
  task automatic tick();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = en & ~m_hold & ~clr;
    chk("sn_ready_a", ifa.sn_ready, exp_rdy);
    chk("sn_ready_b", ifb.sn_ready, exp_rdy);
    @(posedge clk);
    model_update();
    #1;
    check_outs();
  endtask

  task automatic send_frame(input bitq_t q, input int gap_pct, input bit rnd_zr, input bit close);
    int guard;
    for (int i = 0; i < q.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        en       = 1'($urandom_range(0, 1));
        sn_valid = en ? 1'b0 : 1'($urandom_range(0, 1));
        sn_in    = 1'($urandom_range(0, 1));
        sn_last  = 1'($urandom_range(0, 1));
        if (rnd_zr) z_ready = 1'($urandom_range(0, 1));
        tick();
      end
      en       = 1'b1;
      sn_valid = 1'b1;
      sn_in    = q[i];
      sn_last  = close && (i == q.size() - 1);
      guard    = 0;
      do begin
        if (rnd_zr) z_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end while (!m_acc && guard < 64);
      if (!m_acc) begin
        n_err++;
        $error("FAIL accept_timeout observed=no_accept expected=accept");
      end
    end
    sn_valid = 1'b0;
    sn_last  = 1'b0;
    sn_in    = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard;
    z_ready = 1'b1;
    guard   = 0;
    while (m_hold && guard < 20) begin
      tick();
      guard++;
    end
    if (m_hold) begin
      n_err++;
      $error("FAIL drain_timeout observed=hold expected=idle");
    end
    tick();
  endtask

  initial begin
    bitq_t q;

    rst = 1'b0; en = 1'b1; clr = 1'b0; sn_in = 1'b0;
    sn_valid = 1'b0; sn_last = 1'b0; z_ready = 1'b1;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // 256-bit frame, 100 ones at random positions, continuous valid.
    send_frame(make_frame(256, 100), 0, 0, 1);
    drain();

    // Single-bit frame, then 16 zeros.
    q = {1'b1};
    send_frame(q, 0, 0, 1);
    drain();
    send_frame(make_frame(16, 0), 0, 0, 1);
    drain();

    // Backpressure: result held while the producer keeps offering bits.
    z_ready = 1'b0;
    send_frame(make_frame(16, 9), 0, 0, 1);
    sn_valid = 1'b1; sn_in = 1'b1; sn_last = 1'b0;
    repeat (5) tick();
    z_ready = 1'b1;
    send_frame(make_frame(8, 3), 0, 0, 1);
    drain();

    // Gaps mid-frame: en low (with stray sn_last), then valid low.
    send_frame(make_frame(8, 8), 0, 0, 0);
    en = 1'b0; sn_valid = 1'b1; sn_in = 1'b1; sn_last = 1'b1;
    repeat (3) tick();
    en = 1'b1; sn_valid = 1'b0;
    repeat (2) tick();
    send_frame(make_frame(8, 8), 0, 0, 1);
    drain();

    // Saturation on the narrow instance, then a fresh short frame.
    send_frame(make_frame(20, 20), 0, 0, 1);
    drain();
    send_frame(make_frame(4, 2), 0, 0, 1);
    drain();

    // Abort by clr at bit 7.
    send_frame(make_frame(7, 4), 0, 0, 0);
    clr = 1'b1; sn_valid = 1'b1; sn_in = 1'b1; sn_last = 1'b1;
    tick();
    clr = 1'b0; sn_valid = 1'b0; sn_last = 1'b0;
    tick();
    send_frame(make_frame(8, 3), 0, 0, 1);
    drain();

    // Abort by asynchronous reset at bit 7.
    send_frame(make_frame(7, 5), 0, 0, 0);
    sn_valid = 1'b1; sn_in = 1'b1;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_held");
    rst = 1'b1; sn_valid = 1'b0;
    tick();
    send_frame(make_frame(8, 3), 0, 0, 1);
    drain();

    // Random frames with random gaps and result stalls.
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 40);
      send_frame(make_frame(n, $urandom_range(0, n)), 25, 1, 1);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
